// File: rtl/sd_pkg.sv
// Shared constants for the SD initialisation sequencer: command indices,
// fixed arguments, card type encodings and the sequencer state set.
package sd_pkg;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD2   = 6'd2;
  localparam logic [5:0] CMD3   = 6'd3;
  localparam logic [5:0] CMD7   = 6'd7;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD16  = 6'd16;
  localparam logic [5:0] CMD17  = 6'd17;
  localparam logic [5:0] ACMD41 = 6'd41;
  localparam logic [5:0] CMD55  = 6'd55;

  localparam logic [11:0] CMD8_CHECK     = 12'h1AA;
  localparam logic [31:0] CMD8_ARG       = 32'h0000_01AA;
  localparam logic [31:0] ACMD41_ARG_HCS = 32'h4010_0000;
  localparam logic [31:0] ACMD41_ARG_SD  = 32'h0010_0000;
  localparam logic [31:0] BLOCK_LEN      = 32'd512;
  // R1 bits [31:19] are the error flags; lower bits are state/status only.
  localparam logic [31:0] R1_ERR_MASK    = 32'hFFF8_0000;

  localparam logic [1:0] CARD_UNKNOWN = 2'd0;
  localparam logic [1:0] CARD_SDV1    = 2'd1;
  localparam logic [1:0] CARD_SDV2    = 2'd2;
  localparam logic [1:0] CARD_SDHC    = 2'd3;

  typedef enum logic [3:0] {
    ST_CMD0, ST_CMD8, ST_CMD55, ST_ACMD41, ST_CMD2, ST_CMD3,
    ST_CMD7, ST_CMD16, ST_CMD17, ST_FINISH, ST_READY, ST_ERROR
  } state_t;

endpackage

// File: rtl/sd_init_seq.sv
// SD card initialisation and single-block read command sequencer that drives
// the command-line controller; each command state has an ISSUE and a WAIT phase.
module sd_init_seq
  import sd_pkg::*;
#(
  parameter logic [15:0] CLKDIV_INIT  = 16'd78,
  parameter logic [15:0] CLKDIV_FAST  = 16'd1,
  parameter logic [15:0] PRECNT_INIT  = 16'd80,
  parameter logic [15:0] PRECNT_CMD   = 16'd8,
  parameter logic [15:0] PRECNT_R2    = 16'd96,
  parameter logic [15:0] ACMD41_TRIES = 16'd2000,
  parameter logic [1:0]  CMD_RETRIES  = 2'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reinit,
  output logic [15:0] clkdiv,
  output logic        cmd_start,
  output logic [15:0] cmd_precnt,
  output logic [5:0]  cmd_cmd,
  output logic [31:0] cmd_arg,
  input  logic        cmd_busy,
  input  logic        cmd_done,
  input  logic        cmd_timeout,
  input  logic        cmd_syntaxe,
  input  logic [31:0] cmd_resparg,
  input  logic        rd_req,
  input  logic [31:0] rd_sector,
  output logic        rd_ack,
  output logic        rd_ok,
  output logic        rd_err,
  output logic        init_done,
  output logic        init_err,
  output logic [1:0]  card_type
);

  state_t      state;
  logic        waiting;
  logic        v1;
  logic        reinit_pend;
  logic [1:0]  retry;
  logic [15:0] tries;
  logic [15:0] rca;
  logic        failed;

  assign failed = cmd_timeout | cmd_syntaxe;

  task restart();
    state       <= ST_CMD0;
    waiting     <= 1'b0;
    v1          <= 1'b0;
    reinit_pend <= 1'b0;
    retry       <= 2'd0;
    tries       <= 16'd0;
    rca         <= 16'd0;
    clkdiv      <= CLKDIV_INIT;
    cmd_start   <= 1'b0;
    cmd_precnt  <= PRECNT_INIT;
    cmd_cmd     <= CMD0;
    cmd_arg     <= 32'd0;
    rd_ack      <= 1'b0;
    rd_ok       <= 1'b0;
    rd_err      <= 1'b0;
    init_done   <= 1'b0;
    init_err    <= 1'b0;
    card_type   <= CARD_UNKNOWN;
  endtask

  // Command fields are loaded on entry so they are stable from the first ISSUE cycle.
  task enter(input state_t s, input logic [5:0] idx, input logic [31:0] arg,
             input logic [15:0] pre);
    state      <= s;
    waiting    <= 1'b0;
    retry      <= 2'd0;
    cmd_cmd    <= idx;
    cmd_arg    <= arg;
    cmd_precnt <= pre;
  endtask

  task go_error();
    state     <= ST_ERROR;
    waiting   <= 1'b0;
    init_err  <= 1'b1;
    init_done <= 1'b0;
  endtask

  task retry_or_fail();
    if (retry < CMD_RETRIES) begin
      retry   <= retry + 2'd1;
      waiting <= 1'b0;
    end else begin
      go_error();
    end
  endtask

  // A reinit that lands mid-command is held until cmd_done so no start pulse
  // can reach the controller while it is still busy with the old command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      restart();
    end else begin
      cmd_start <= 1'b0;
      rd_ack    <= 1'b0;
      rd_ok     <= 1'b0;
      rd_err    <= 1'b0;
      if ((reinit || reinit_pend) && (!waiting || cmd_done)) begin
        restart();
      end else if (reinit) begin
        reinit_pend <= 1'b1;
      end else if (!reinit_pend) begin
        if (!waiting) begin
          case (state)
            ST_FINISH: begin
              clkdiv    <= CLKDIV_FAST;
              init_done <= 1'b1;
              state     <= ST_READY;
            end
            ST_READY: begin
              if (rd_req) begin
                rd_ack <= 1'b1;
                enter(ST_CMD17, CMD17,
                      (card_type == CARD_SDHC) ? rd_sector : {rd_sector[22:0], 9'd0},
                      PRECNT_CMD);
              end
            end
            ST_ERROR: ;
            default: begin
              if (!cmd_busy) begin
                cmd_start <= 1'b1;
                waiting   <= 1'b1;
              end
            end
          endcase
        end else if (cmd_done) begin
          case (state)
            ST_CMD0: enter(ST_CMD8, CMD8, CMD8_ARG, PRECNT_CMD);
            ST_CMD8: begin
              if (cmd_timeout) begin
                v1 <= 1'b1;
                enter(ST_CMD55, CMD55, 32'd0, PRECNT_CMD);
              end else if (!cmd_syntaxe && cmd_resparg[11:0] == CMD8_CHECK) begin
                v1 <= 1'b0;
                enter(ST_CMD55, CMD55, 32'd0, PRECNT_CMD);
              end else begin
                go_error();
              end
            end
            ST_CMD55: begin
              if (failed) retry_or_fail();
              else enter(ST_ACMD41, ACMD41, v1 ? ACMD41_ARG_SD : ACMD41_ARG_HCS, PRECNT_CMD);
            end
            ST_ACMD41: begin
              if (!cmd_timeout && cmd_resparg[31]) begin
                card_type <= v1 ? CARD_SDV1 : (cmd_resparg[30] ? CARD_SDHC : CARD_SDV2);
                enter(ST_CMD2, CMD2, 32'd0, PRECNT_CMD);
              end else if (tries + 16'd1 == ACMD41_TRIES) begin
                go_error();
              end else begin
                tries <= tries + 16'd1;
                enter(ST_CMD55, CMD55, 32'd0, PRECNT_CMD);
              end
            end
            ST_CMD2: begin
              if (cmd_timeout) retry_or_fail();
              else enter(ST_CMD3, CMD3, 32'd0, PRECNT_R2);
            end
            ST_CMD3: begin
              if (failed) begin
                retry_or_fail();
              end else begin
                rca <= cmd_resparg[31:16];
                enter(ST_CMD7, CMD7, {cmd_resparg[31:16], 16'h0}, PRECNT_CMD);
              end
            end
            ST_CMD7: begin
              if (failed) begin
                retry_or_fail();
              end else if (card_type == CARD_SDHC) begin
                state   <= ST_FINISH;
                waiting <= 1'b0;
                retry   <= 2'd0;
              end else begin
                enter(ST_CMD16, CMD16, BLOCK_LEN, PRECNT_CMD);
              end
            end
            ST_CMD16: begin
              if (failed) begin
                retry_or_fail();
              end else begin
                state   <= ST_FINISH;
                waiting <= 1'b0;
                retry   <= 2'd0;
              end
            end
            ST_CMD17: begin
              if (!failed && (cmd_resparg & R1_ERR_MASK) == 32'd0) rd_ok <= 1'b1;
              else rd_err <= 1'b1;
              state   <= ST_READY;
              waiting <= 1'b0;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
